// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered LSU results onto
// the single registered regfile write port, ALU first with a starvation guard for the LSU.
module wb_arbiter #(
    parameter int XLEN           = 64,
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4,
    localparam int CNT_W         = $clog2(LSU_FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid_i,
    output logic             alu_ready_o,
    input  logic [4:0]       alu_rd_i,
    input  logic [XLEN-1:0]  alu_data_i,
    input  logic             lsu_valid_i,
    output logic             lsu_ready_o,
    input  logic [4:0]       lsu_rd_i,
    input  logic [XLEN-1:0]  lsu_data_i,
    output logic [4:0]       w_addr_o,
    output logic [XLEN-1:0]  w_data_o,
    output logic             w_ena_o,
    output logic [CNT_W-1:0] fifo_count_o
);

    localparam int PTR_W = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [4:0]       w_addr_q, w_addr_d;
    logic [XLEN-1:0]  w_data_q, w_data_d;
    logic             w_ena_q, w_ena_d;

    logic [4:0]       mem_rd   [LSU_FIFO_DEPTH];
    logic [XLEN-1:0]  mem_data [LSU_FIFO_DEPTH];

    logic force_lsu, fifo_empty, fifo_full;
    logic alu_fire, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // explicit wrap so non-power-of-2 depths work
        if (p == PTR_W'(LSU_FIFO_DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Readies come from flops and rst only; no valid->ready path.
    assign force_lsu   = (starve_q == STV_W'(STARVE_LIMIT));
    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(LSU_FIFO_DEPTH));
    assign alu_ready_o = !rst && !force_lsu;
    assign lsu_ready_o = !rst && !fifo_full;

    assign alu_fire = alu_valid_i && alu_ready_o && (alu_rd_i != 5'd0);
    assign pop      = !alu_fire && !fifo_empty;
    assign push     = lsu_valid_i && lsu_ready_o && (lsu_rd_i != 5'd0);

    always_comb begin
        w_ena_d  = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (alu_fire) begin
            w_ena_d  = 1'b1;
            w_addr_d = alu_rd_i;
            w_data_d = alu_data_i;
        end else if (pop) begin
            w_ena_d  = 1'b1;
            w_addr_d = mem_rd[rd_ptr_q];
            w_data_d = mem_data[rd_ptr_q];
        end

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        starve_d = starve_q;
        if (pop || fifo_empty)
            starve_d = '0;
        else if (!force_lsu)
            starve_d = starve_q + STV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            starve_q <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            w_ena_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            starve_q <= starve_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            w_ena_q  <= w_ena_d;
        end
    end

    // Storage needs no reset: entries are only read when count_q says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr_q]   <= lsu_rd_i;
            mem_data[wr_ptr_q] <= lsu_data_i;
        end
    end

    assign w_addr_o     = w_addr_q;
    assign w_data_o     = w_data_q;
    assign w_ena_o      = w_ena_q;
    assign fifo_count_o = count_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && fifo_empty));
    a_wena_addr:    assert property (@(posedge clk) disable iff (rst) w_ena_q |-> (w_addr_q != 5'd0));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, all checked against
// a queue-based reference model of the writeback rules.
module tb_wb_arbiter;

    localparam int XLEN  = 64;
    localparam int DEPTH = 3;
    localparam int LIMIT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0]       alu_rd = '0, lsu_rd = '0;
    logic [XLEN-1:0]  alu_data = '0, lsu_data = '0;
    logic             alu_ready, lsu_ready, w_ena;
    logic [4:0]       w_addr;
    logic [XLEN-1:0]  w_data;
    logic [1:0]       fifo_count;

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(XLEN), .LSU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
        .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
        .w_addr_o(w_addr), .w_data_o(w_data), .w_ena_o(w_ena), .fifo_count_o(fifo_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q[$];
    int              m_starve;
    logic            m_ena;
    logic [4:0]      m_addr;
    logic [XLEN-1:0] m_data;
    bit              m_ar, m_lr;
    int              lsu_acc;

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_ena    = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    task automatic drv(input bit av, input logic [4:0] ard, input logic [63:0] ad,
                       input bit lv, input logic [4:0] lrd, input logic [63:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    endtask

    // One clock: check readies mid-cycle, predict, then check registered outputs.
    task automatic step();
        bit   fire, pop_now, push_now, was_empty;
        ent_t e;
        @(negedge clk);
        m_ar = (m_starve != LIMIT);
        m_lr = (q.size() < DEPTH);
        check("alu_ready", alu_ready, m_ar);
        check("lsu_ready", lsu_ready, m_lr);
        was_empty = (q.size() == 0);
        fire      = alu_valid && m_ar && (alu_rd != 0);
        pop_now   = !fire && !was_empty;
        push_now  = lsu_valid && m_lr && (lsu_rd != 0);
        if (lsu_valid && m_lr) lsu_acc++;
        if (fire) begin
            m_ena = 1'b1; m_addr = alu_rd; m_data = alu_data;
        end else if (pop_now) begin
            e = q.pop_front();
            m_ena = 1'b1; m_addr = e.rd; m_data = e.data;
        end else begin
            m_ena = 1'b0;
        end
        if (pop_now || was_empty) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        if (push_now) begin
            e.rd = lsu_rd; e.data = lsu_data;
            q.push_back(e);
        end
        @(posedge clk); #1;
        check("w_ena", w_ena, m_ena);
        check("w_addr", w_addr, m_addr);
        check("w_data", w_data, m_data);
        check("fifo_count", fifo_count, q.size());
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int  t2, t3, cyc;
        bit  held_alu, held_lsu;
        lsu_acc = 0;
        model_reset();

        // reset with random inputs
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv($urandom_range(0, 1), 5'($urandom), {$urandom, $urandom},
                $urandom_range(0, 1), 5'($urandom), {$urandom, $urandom});
            @(negedge clk);
            check("rst_w_ena", w_ena, 0);
            check("rst_w_addr", w_addr, 0);
            check("rst_w_data", w_data, 0);
            check("rst_fifo_count", fifo_count, 0);
            check("rst_alu_ready", alu_ready, 0);
            check("rst_lsu_ready", lsu_ready, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        step();

        // single ALU write, then single LSU write (two-cycle latency)
        drv(1, 5, 64'h1234, 0, 0, 0);
        step();
        check("alu_lat_ena", w_ena, 1);
        check("alu_lat_addr", w_addr, 5);
        check("alu_lat_data", w_data, 64'h1234);
        drv(0, 0, 0, 1, 7, 64'hABCD);
        step();
        check("lsu_lat_n1", w_ena, 0);
        idle();
        step();
        check("lsu_lat_ena", w_ena, 1);
        check("lsu_lat_addr", w_addr, 7);
        check("lsu_lat_data", w_data, 64'hABCD);
        idle();
        step();

        // contention: ALU every cycle, LSU forced through after LIMIT blocked cycles
        t2 = -1; t3 = -1;
        for (int k = 0; k < 14; k++) begin
            drv(1, 1, 64'h11, k < 2, (k == 0) ? 5'd2 : 5'd3, 64'h200 + 64'(k));
            step();
            if (w_ena && w_addr == 2 && t2 < 0) t2 = k;
            if (w_ena && w_addr == 3 && t3 < 0) t3 = k;
        end
        check("starve_rd2_cycle", t2, 5);
        check("starve_rd3_cycle", t3, 10);
        idle();
        step();

        // x0 filtering
        drv(0, 0, 0, 1, 9, 64'h99);
        step();
        drv(1, 0, 64'hDEAD, 0, 0, 0);
        step();
        check("x0_alu_head_ena", w_ena, 1);
        check("x0_alu_head_addr", w_addr, 9);
        drv(0, 0, 0, 1, 0, 64'h55);
        step();
        check("x0_lsu_count", fifo_count, 0);
        check("x0_lsu_ena", w_ena, 0);

        // fill the FIFO, then offer a push in the forced-pop cycle while full
        for (int k = 0; k < 16; k++) begin
            if (k < 3) drv(1, 1, 64'h77, 1, 5'(10 + k), 64'h300 + 64'(k));
            else       drv(1, 1, 64'h77, 1, 13, 64'h313);
            step();
        end
        idle();
        for (int k = 0; k < 8; k++) step();

        // random traffic: ALU ~50%, LSU results scoreboarded through the model queue
        held_alu = 0; held_lsu = 0; cyc = 0;
        while (lsu_acc < 1000 && cyc < 20000) begin
            if (!held_alu) begin
                alu_valid = $urandom_range(0, 1);
                alu_rd    = 5'($urandom);
                alu_data  = {$urandom, $urandom};
            end
            if (!held_lsu) begin
                lsu_valid = ($urandom_range(0, 9) < 4);
                lsu_rd    = 5'($urandom);
                lsu_data  = {$urandom, $urandom};
            end
            step();
            held_alu = alu_valid && !m_ar;
            held_lsu = lsu_valid && !m_lr;
            cyc++;
        end
        check("random_budget", lsu_acc >= 1000, 1);
        idle();
        cyc = 0;
        while (q.size() != 0 && cyc < 50) begin
            step();
            cyc++;
        end
        check("drain_empty", q.size(), 0);

        // reset mid-operation with two entries buffered
        drv(1, 1, 64'h88, 1, 20, 64'h400);
        step();
        drv(1, 1, 64'h88, 1, 21, 64'h401);
        step();
        drv(1, 1, 64'h88, 0, 0, 0);
        step();
        check("midrst_pre_count", fifo_count, 2);
        #2 rst = 1'b1;
        #1;
        check("midrst_w_ena", w_ena, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_alu_ready", alu_ready, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        for (int k = 0; k < 10; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
